// File: rtl/intr_pkg.sv
// Shared defaults and the channel-vector helper for the interrupt controller.
package intr_pkg;

    localparam int DEF_NCH        = 4;
    localparam int DEF_PCW        = 10;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_VEC_BASE   = 'h3C0;
    localparam int DEF_VEC_STRIDE = 16;

    // Untruncated vector address; callers cut it down to their PC width.
    function automatic int unsigned chan_vector(input int unsigned base,
                                                input int unsigned stride,
                                                input int unsigned ch);
        return base + ch * stride;
    endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Signal bundle between the CPU core (master) and the interrupt controller (slave).
interface intr_ctrl_if #(
    parameter int NCH = intr_pkg::DEF_NCH,
    parameter int PCW = intr_pkg::DEF_PCW
);
    logic [NCH-1:0] irq;
    logic           gie;
    logic           mask_we;
    logic [NCH-1:0] mask_wd;
    logic [PCW-1:0] pc_ret;
    logic           reti;
    logic           take;
    logic [PCW-1:0] vector;
    logic [PCW-1:0] ret_pc;
    logic [NCH-1:0] in_service;
    logic           stk_full;
    logic           stk_err;

    modport master (
        output irq, gie, mask_we, mask_wd, pc_ret, reti,
        input  take, vector, ret_pc, in_service, stk_full, stk_err
    );

    modport slave (
        input  irq, gie, mask_we, mask_wd, pc_ret, reti,
        output take, vector, ret_pc, in_service, stk_full, stk_err
    );
endinterface

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder: the lowest-numbered set request wins.
module prio_enc #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  onehot_o,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IW'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/intr_ctrl.sv
// Nested fixed-priority interrupt controller with a return-address stack.
// Define INTR_EDGE_EN for edge-captured requests; level mode otherwise.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int             NCH        = DEF_NCH,
    parameter int             PCW        = DEF_PCW,
    parameter int             DEPTH      = DEF_DEPTH,
    parameter logic [PCW-1:0] VEC_BASE   = PCW'(DEF_VEC_BASE),
    parameter int             VEC_STRIDE = DEF_VEC_STRIDE
) (
    input logic        clk,
    input logic        reset,
    intr_ctrl_if.slave bus
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(NCH);

    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] mask_q;
    logic [NCH-1:0] in_service_q, in_service_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           stk_err_q, stk_err_d;
    logic [PCW-1:0] stk_q [DEPTH];

    logic [NCH-1:0] eligible;
    logic [NCH-1:0] el_onehot, is_onehot;
    logic           el_valid, is_valid;
    logic [IW-1:0]  el_idx, is_idx;
    logic           stk_full;
    logic           take;
    logic [PCW-1:0] ret_pc;

    assign eligible = pending_q & mask_q & ~in_service_q;

    prio_enc #(.N(NCH), .IW(IW)) u_enc_el (
        .req_i    (eligible),
        .onehot_o (el_onehot),
        .valid_o  (el_valid),
        .idx_o    (el_idx)
    );

    prio_enc #(.N(NCH), .IW(IW)) u_enc_is (
        .req_i    (in_service_q),
        .onehot_o (is_onehot),
        .valid_o  (is_valid),
        .idx_o    (is_idx)
    );

    assign stk_full = (sp_q == SPW'(DEPTH));

    // reti always wins over a coinciding request; the request retries next cycle.
    assign take = reset && bus.gie && el_valid && (!is_valid || (el_idx < is_idx))
                  && !stk_full && !bus.reti;

`ifdef INTR_EDGE_EN
    logic [NCH-1:0] irq_prev_q;
    // A fresh edge in the take cycle re-arms the bit it would have cleared.
    assign pending_d = (pending_q & ~(take ? el_onehot : '0)) | (bus.irq & ~irq_prev_q);
`else
    assign pending_d = bus.irq;
`endif

    always_comb begin
        in_service_d = in_service_q;
        sp_d         = sp_q;
        stk_err_d    = stk_err_q;
        if (take) begin
            in_service_d = in_service_q | el_onehot;
            sp_d         = sp_q + SPW'(1);
        end else if (bus.reti) begin
            if (sp_q != '0) begin
                in_service_d = in_service_q & ~is_onehot;
                sp_d         = sp_q - SPW'(1);
            end else begin
                stk_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q    <= '0;
            mask_q       <= '0;
            in_service_q <= '0;
            sp_q         <= '0;
            stk_err_q    <= 1'b0;
`ifdef INTR_EDGE_EN
            irq_prev_q   <= '0;
`endif
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            sp_q         <= sp_d;
            stk_err_q    <= stk_err_d;
            if (bus.mask_we) begin
                mask_q <= bus.mask_wd;
            end
`ifdef INTR_EDGE_EN
            irq_prev_q   <= bus.irq;
`endif
        end
    end

    // Stack contents need no reset: a cleared pointer hides every stale entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (take && (sp_q == SPW'(i))) begin
                stk_q[i] <= bus.pc_ret;
            end
        end
    end

    always_comb begin
        ret_pc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) begin
                ret_pc = stk_q[i];
            end
        end
    end

    assign bus.take       = take;
    assign bus.vector     = take ? PCW'(chan_vector(32'(VEC_BASE), 32'(VEC_STRIDE), 32'(el_idx)))
                                 : '0;
    assign bus.ret_pc     = ret_pc;
    assign bus.in_service = in_service_q;
    assign bus.stk_full   = stk_full;
    assign bus.stk_err    = stk_err_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed scenarios then random traffic, every cycle compared to a queue-based model.
module tb_intr_ctrl;

    localparam int NCH   = 8;
    localparam int PCW   = 10;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    intr_ctrl_if #(.NCH(NCH), .PCW(PCW)) bus ();

    intr_ctrl #(.NCH(NCH), .PCW(PCW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;
    bit do_check;

    // Reference model state
    logic [NCH-1:0] m_pend, m_mask, m_isv, m_prev;
    logic           m_err;
    logic [PCW-1:0] m_stack [$];
    int             m_e, m_s;
    bit             m_take;

    function automatic int first_set(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) begin
            if (v[i]) return i;
        end
        return NCH;
    endfunction

    function automatic logic [PCW-1:0] vec_of(input int ch);
        return PCW'(32'h3C0 + ch * 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic rst_v, input logic [NCH-1:0] irq_v, input logic gie_v,
                         input logic rt_v, input logic mwe_v, input logic [NCH-1:0] mwd_v,
                         input logic [PCW-1:0] pc_v);
        logic [PCW-1:0] exp_ret;
        reset       = rst_v;
        bus.irq     = irq_v;
        bus.gie     = gie_v;
        bus.reti    = rt_v;
        bus.mask_we = mwe_v;
        bus.mask_wd = mwd_v;
        bus.pc_ret  = pc_v;
        #1;
        m_e    = first_set(m_pend & m_mask & ~m_isv);
        m_s    = first_set(m_isv);
        m_take = rst_v && gie_v && (m_e < NCH) && (m_e < m_s)
                 && (m_stack.size() < DEPTH) && !rt_v;
        if (m_stack.size() > 0) exp_ret = m_stack[m_stack.size() - 1];
        else                    exp_ret = '0;
        if (do_check) begin
            chk("take",       32'(bus.take),       32'(m_take));
            chk("vector",     32'(bus.vector),     m_take ? 32'(vec_of(m_e)) : 32'd0);
            chk("ret_pc",     32'(bus.ret_pc),     32'(exp_ret));
            chk("in_service", 32'(bus.in_service), 32'(m_isv));
            chk("stk_full",   32'(bus.stk_full),   32'(m_stack.size() == DEPTH));
            chk("stk_err",    32'(bus.stk_err),    32'(m_err));
        end
        $display("[TB] t=%0t rst=%b irq=%h gie=%b reti=%b mwe=%b take=%b vec=%h is=%h ret=%h full=%b err=%b",
                 $time, rst_v, irq_v, gie_v, rt_v, mwe_v, bus.take, bus.vector,
                 bus.in_service, bus.ret_pc, bus.stk_full, bus.stk_err);
    endtask

    task automatic tick();
        logic [NCH-1:0] np;
        if (!reset) begin
            m_pend = '0;
            m_mask = '0;
            m_isv  = '0;
            m_prev = '0;
            m_err  = 1'b0;
            m_stack.delete();
        end else begin
`ifdef INTR_EDGE_EN
            for (int i = 0; i < NCH; i++) begin
                if (bus.irq[i] && !m_prev[i])   np[i] = 1'b1;
                else if (m_take && (i == m_e))  np[i] = 1'b0;
                else                            np[i] = m_pend[i];
            end
`else
            np = bus.irq;
`endif
            if (m_take) begin
                m_stack.push_back(bus.pc_ret);
                m_isv = m_isv | (NCH'(1) << m_e);
            end else if (bus.reti) begin
                if (m_stack.size() > 0) begin
                    void'(m_stack.pop_back());
                    m_isv = m_isv & ~(NCH'(1) << m_s);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (bus.mask_we) m_mask = bus.mask_wd;
            m_prev = bus.irq;
            m_pend = np;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Common cycle: out of reset, gie on, no mask write.
    task automatic cyc(input logic [NCH-1:0] irq_v, input logic rt_v, input logic [PCW-1:0] pc_v);
        drive(1'b1, irq_v, 1'b1, rt_v, 1'b0, '0, pc_v);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        do_check     = 1'b0;

        // Reset
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0); tick();
        do_check = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("rst_take", 32'(bus.take), 32'd0);
        chk("rst_vector", 32'(bus.vector), 32'd0);
        chk("rst_ret_pc", 32'(bus.ret_pc), 32'd0);
        chk("rst_full", 32'(bus.stk_full), 32'd0);
        chk("rst_err", 32'(bus.stk_err), 32'd0);
        tick();

        // First entry on channel 2
        drive(1'b1, '0, 1'b1, 1'b0, 1'b1, 8'h0F, '0); tick();
        cyc(8'h04, 1'b0, '0); tick();
        cyc(8'h00, 1'b0, 10'h055);
        chk("ch2_take", 32'(bus.take), 32'd1);
        chk("ch2_vector", 32'(bus.vector), 32'h3E0);
        tick();
        cyc(8'h00, 1'b0, '0);
        chk("ch2_is", 32'(bus.in_service), 32'h04);
        chk("ch2_ret", 32'(bus.ret_pc), 32'h055);
        tick();

        // Channel 0 nests over channel 2, then returns
        cyc(8'h01, 1'b0, '0); tick();
        cyc(8'h00, 1'b0, 10'h0A1);
        chk("ch0_take", 32'(bus.take), 32'd1);
        chk("ch0_vector", 32'(bus.vector), 32'h3C0);
        tick();
        cyc(8'h00, 1'b1, '0);
        chk("nest_is", 32'(bus.in_service), 32'h05);
        chk("nest_ret", 32'(bus.ret_pc), 32'h0A1);
        tick();
        cyc(8'h00, 1'b0, '0);
        chk("reti_is", 32'(bus.in_service), 32'h04);
        chk("reti_ret", 32'(bus.ret_pc), 32'h055);
        tick();
        cyc(8'h00, 1'b1, '0); tick();

        // Lower-priority channel 3 waits behind channel 1
        cyc(8'h02, 1'b0, '0); tick();
        cyc(8'h00, 1'b0, 10'h111); tick();
        cyc(8'h08, 1'b0, '0); tick();
        cyc(8'h08, 1'b0, '0);
        chk("ch3_blocked", 32'(bus.take), 32'd0);
        tick();
        cyc(8'h08, 1'b1, '0); tick();
        cyc(8'h08, 1'b0, 10'h123);
        chk("ch3_take", 32'(bus.take), 32'd1);
        chk("ch3_vector", 32'(bus.vector), 32'h3F0);
        tick();
        cyc(8'h00, 1'b1, '0); tick();

        // Fill the stack with channels 7..4, then channel 0 must wait
        drive(1'b1, '0, 1'b1, 1'b0, 1'b1, 8'hFF, '0); tick();
        cyc(8'h80, 1'b0, '0); tick();
        cyc(8'hC0, 1'b0, 10'h201); tick();
        cyc(8'hE0, 1'b0, 10'h202); tick();
        cyc(8'hF0, 1'b0, 10'h203); tick();
        cyc(8'hF0, 1'b0, 10'h204); tick();
        cyc(8'hF1, 1'b0, '0);
        chk("full_flag", 32'(bus.stk_full), 32'd1);
        tick();
        cyc(8'hF1, 1'b0, '0);
        chk("full_take", 32'(bus.take), 32'd0);
        chk("full_flag2", 32'(bus.stk_full), 32'd1);
        tick();
        cyc(8'hF1, 1'b1, '0);
        chk("full_reti_take", 32'(bus.take), 32'd0);
        tick();
        cyc(8'hF1, 1'b0, 10'h300);
        chk("after_full_take", 32'(bus.take), 32'd1);
        chk("after_full_vec", 32'(bus.vector), 32'h3C0);
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            cyc(8'h00, 1'b1, '0); tick();
        end

        // reti on an empty stack
        cyc(8'h00, 1'b1, '0); tick();
        cyc(8'h00, 1'b0, '0);
        chk("err_set", 32'(bus.stk_err), 32'd1);
        chk("err_is", 32'(bus.in_service), 32'd0);
        chk("err_ret", 32'(bus.ret_pc), 32'd0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0); tick();
        cyc(8'h00, 1'b0, '0);
        chk("err_clear", 32'(bus.stk_err), 32'd0);
        tick();

        // reti coinciding with an eligible request
        drive(1'b1, '0, 1'b1, 1'b0, 1'b1, 8'hFF, '0); tick();
        cyc(8'h02, 1'b0, '0); tick();
        cyc(8'h02, 1'b1, '0);
        chk("coinc_take0", 32'(bus.take), 32'd0);
        tick();
        cyc(8'h02, 1'b0, 10'h3AA);
        chk("coinc_take1", 32'(bus.take), 32'd1);
        chk("coinc_vec", 32'(bus.vector), 32'h3D0);
        tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 99) != 0),
                  NCH'($urandom & $urandom & $urandom),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0),
                  NCH'($urandom),
                  PCW'($urandom));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
